// File: rtl/regfile_writeback_unit.sv
// Register writeback collector: mem/alu arbitration, r0 filter, in-order FIFO retire.
// Optional WB_BYPASS_EN adds two combinational forwarding ports from FIFO entries.
module regfile_writeback_unit #(
    parameter int DEPTH = 4,
    parameter int AW    = 5,
    parameter int DW    = 32
) (
    input  logic                   clock,
    input  logic                   reset_n,
    input  logic                   alu_valid,
    input  logic [AW-1:0]          alu_addr,
    input  logic [DW-1:0]          alu_data,
    output logic                   alu_ready,
    input  logic                   mem_valid,
    input  logic [AW-1:0]          mem_addr,
    input  logic [DW-1:0]          mem_data,
    output logic                   mem_ready,
    input  logic                   wb_stall,
    output logic                   RegWrite,
    output logic [AW-1:0]          WriteAddr,
    output logic [DW-1:0]          WriteData,
    output logic [$clog2(DEPTH):0] count,
`ifdef WB_BYPASS_EN
    input  logic [AW-1:0]          byp_addr1,
    input  logic [AW-1:0]          byp_addr2,
    output logic                   byp_hit1,
    output logic                   byp_hit2,
    output logic [DW-1:0]          byp_data1,
    output logic [DW-1:0]          byp_data2,
`endif
    output logic                   busy
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [AW-1:0] addr_q [DEPTH];
    logic [DW-1:0] data_q [DEPTH];
    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] wr_ptr;
    logic [CW-1:0] cnt;

    logic          pop;
    logic          push;
    logic          space;
    logic [AW-1:0] in_addr;
    logic [DW-1:0] in_data;

    always_comb begin
        busy      = (cnt != '0);
        pop       = busy && !wb_stall;
        space     = (cnt < CW'(DEPTH)) || pop;
        mem_ready = reset_n && mem_valid && space;
        alu_ready = reset_n && alu_valid && space && !mem_valid;
        in_addr   = mem_valid ? mem_addr : alu_addr;
        in_data   = mem_valid ? mem_data : alu_data;
        // r0 writes are acknowledged but never stored
        push      = (mem_ready || alu_ready) && (in_addr != '0);
        RegWrite  = pop;
        WriteAddr = busy ? addr_q[rd_ptr] : '0;
        WriteData = busy ? data_q[rd_ptr] : '0;
        count     = cnt;
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            unique case ({push, pop})
                2'b10:   cnt <= cnt + 1'b1;
                2'b01:   cnt <= cnt - 1'b1;
                default: cnt <= cnt;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (push) begin
            addr_q[wr_ptr] <= in_addr;
            data_q[wr_ptr] <= in_data;
        end
    end

`ifdef WB_BYPASS_EN
    // Scan oldest to youngest so the last match wins
    always_comb begin
        logic [PW-1:0] idx;
        idx       = '0;
        byp_hit1  = 1'b0;
        byp_hit2  = 1'b0;
        byp_data1 = '0;
        byp_data2 = '0;
        for (int i = 0; i < DEPTH; i++) begin
            idx = rd_ptr + PW'(i);
            if (CW'(i) < cnt) begin
                if (byp_addr1 != '0 && addr_q[idx] == byp_addr1) begin
                    byp_hit1  = 1'b1;
                    byp_data1 = data_q[idx];
                end
                if (byp_addr2 != '0 && addr_q[idx] == byp_addr2) begin
                    byp_hit2  = 1'b1;
                    byp_data2 = data_q[idx];
                end
            end
        end
    end
`endif

endmodule

// File: doc/regfile_writeback_unit.md
Name: regfile_writeback_unit

Overview:
Collects register writeback requests from the ALU and load/memory paths and drives the register file's write port (RegWrite/WriteAddr/WriteData). One request is accepted per cycle with fixed priority, buffered in a small FIFO, and retired at most one per cycle. A stall input lets another agent, such as the debug loader, own the write port. Writes to r0 are absorbed because the register file hardwires r0 to zero.

Parameters:
DEPTH, 4, FIFO entries; power of two, minimum 2.
AW, 5, register address width.
DW, 32, data width.

Ports:
clock  in  1  system clock, rising edge.
reset_n  in  1  asynchronous active-low reset.
alu_valid  in  1  ALU writeback request.
alu_addr  in  AW  ALU destination register.
alu_data  in  DW  ALU result.
alu_ready  out  1  ALU request accepted this cycle.
mem_valid  in  1  load writeback request.
mem_addr  in  AW  load destination register.
mem_data  in  DW  load data.
mem_ready  out  1  load request accepted this cycle.
wb_stall  in  1  inhibit retirement this cycle.
RegWrite  out  1  register file write enable.
WriteAddr  out  AW  register file write address.
WriteData  out  DW  register file write data.
count  out  log2(DEPTH)+1  FIFO occupancy.
busy  out  1  FIFO non-empty.

Behaviour:
- Reset (async assert, sync release):
  - FIFO pointers and count are 0.
  - RegWrite, busy, alu_ready and mem_ready are 0.
  - WriteAddr and WriteData are 0.
- Retirement:
  - pop = busy && !wb_stall.
  - RegWrite, WriteAddr and WriteData are combinational from the FIFO head.
  - RegWrite = pop.
  - WriteAddr/WriteData hold the head entry whenever busy; they are 0 when empty.
- Acceptance, one request per cycle:
  - space = (count < DEPTH) || pop.
  - mem has fixed priority: mem_ready = mem_valid && space.
  - alu_ready = alu_valid && space && !mem_valid.
  - A request is transferred when valid && ready in the same cycle.
  - The requester holds valid/addr/data stable until ready.
- r0 filter:
  - An accepted request with addr == 0 is acknowledged (ready = 1) but not enqueued.
  - count is unchanged, and it never produces RegWrite.
  - An r0 request still consumes the cycle's acceptance slot.
- Latency:
  - An accepted request in cycle N with an empty FIFO and no stall gives RegWrite high in cycle N+1.
  - The register file is updated at the end of cycle N+1.
  - Pass-through through an empty FIFO is not allowed (no same-cycle bypass).
- Ordering: retirement is strictly in acceptance order; two writes to the same register retire in order.
- Count update:
  - +1 on push only, -1 on pop only, unchanged on both or neither.
  - Pointers wrap modulo DEPTH.
- Full:
  - Push while full is accepted only in a cycle that also pops.
  - If wb_stall is held while full, both ready outputs are 0.
- Empty: a stall while empty has no effect.
- Reset mid-operation: all pending entries are discarded and RegWrite drops immediately, asynchronously.

Optional Feature:
Macro WB_BYPASS_EN.
- When defined, adds ports:
  - byp_addr1/byp_addr2: in, AW each.
  - byp_hit1/byp_hit2: out, 1 each.
  - byp_data1/byp_data2: out, DW each.
- byp_hitN = 1 when some valid FIFO entry, including the head being written this cycle, has addr == byp_addrN and byp_addrN != 0.
- byp_dataN = data of the youngest matching entry; both outputs are combinational.
- On a miss, byp_hitN = 0 and byp_dataN = 0.
- When undefined, the ports and matching logic are absent and the read ports see only the committed register file.

Test Plan:
- Single write: alu_valid with addr 3, data 0xDEADBEEF in cycle 0, no stall → alu_ready=1 in cycle 0; RegWrite=1, WriteAddr=3, WriteData=0xDEADBEEF in cycle 1; busy=0 in cycle 2.
- Priority: alu (5, 0x11) and mem (6, 0x22) both valid in the same cycle → mem_ready=1, alu_ready=0. The ALU holds and is accepted next cycle. Retire order is r6=0x22, then r5=0x11.
- r0 discard: mem_valid with addr 0, data 0xFFFFFFFF → mem_ready=1, count stays 0, RegWrite never asserts.
- Full/stall: wb_stall=1, push 4 ALU writes (r1..r4) → count=4. A fifth request sees alu_ready=0. Release the stall → RegWrite for r1..r4 on 4 consecutive cycles; the fifth is accepted in the first release cycle.
- Wrap-around: 10 back-to-back writes with alternating 1-cycle stalls → all 10 retire in order with correct data; count never exceeds 4.
- Reset mid-operation: assert reset_n=0 with count=3 → RegWrite=0, count=0 immediately. After release, no stale writes are retired.
- (WB_BYPASS_EN) Stall with r7=0xA then r7=0xB queued, byp_addr1=7 → byp_hit1=1, byp_data1=0xB; byp_addr2=0 → byp_hit2=0.
